// File: rtl/audio_out_decimator.sv
// Stereo CIC decimator (STAGES integrators/combs, decimation by RATE) with unity-gain rounding and an output FIFO.
// Optional feature macro: AUDIO_DECIM_SAT_EN clamps results to the IW range; when undefined results wrap.
module audio_out_decimator #(
   parameter int unsigned IW         = 16,
   parameter int unsigned RATE       = 1120,
   parameter int unsigned STAGES     = 2,
   parameter int unsigned GAIN_MUL   = 54783,
   parameter int unsigned GAIN_SHIFT = 36,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_cen,
   input  logic signed [IW-1:0] snd_l_in,
   input  logic signed [IW-1:0] snd_r_in,
   output logic signed [IW-1:0] out_l,
   output logic signed [IW-1:0] out_r,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 overrun
);

   localparam int unsigned LR   = $clog2(RATE);
   localparam int unsigned CW   = IW + STAGES * LR;
   localparam int unsigned PHW  = (LR > 0) ? LR : 1;
   localparam int unsigned PRW  = $clog2(STAGES + 1);
   localparam int unsigned GW   = 18;
   localparam int unsigned PW   = CW + GW;
   localparam int unsigned RW   = PW - GAIN_SHIFT;
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTW = AW + 1;

   localparam logic signed [GW-1:0] GAIN_S  = GW'(GAIN_MUL);
   localparam logic signed [PW-1:0] RND_ADD = PW'(1) << (GAIN_SHIFT - 1);
`ifdef AUDIO_DECIM_SAT_EN
   localparam logic signed [RW-1:0] SAT_MAX = RW'(2 ** (IW - 1) - 1);
   localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;
`endif

   // integrator / phase / priming state
   logic [CW-1:0]  int_l_q [STAGES];
   logic [CW-1:0]  int_l_d [STAGES];
   logic [CW-1:0]  int_r_q [STAGES];
   logic [CW-1:0]  int_r_d [STAGES];
   logic [PHW-1:0] phase_q, phase_d;
   logic [PRW-1:0] prime_q, prime_d;
   logic           strobe_c;

   // comb chain
   logic [CW-1:0]  hist_l_q [STAGES];
   logic [CW-1:0]  hist_l_d [STAGES];
   logic [CW-1:0]  hist_r_q [STAGES];
   logic [CW-1:0]  hist_r_d [STAGES];
   logic [CW-1:0]  cv_l, cv_r;
   logic [CW-1:0]  comb_l_q, comb_l_d, comb_r_q, comb_r_d;
   logic           comb_vld_q, comb_vld_d;

   // gain and rounding pipeline
   logic signed [PW-1:0] prod_l_q, prod_l_d, prod_r_q, prod_r_d;
   logic                 prod_vld_q, prod_vld_d;
   logic [IW-1:0]        res_l_q, res_l_d, res_r_q, res_r_d;
   logic                 res_vld_q, res_vld_d;

   // output FIFO
   logic [IW-1:0]   mem_l_q [FIFO_DEPTH];
   logic [IW-1:0]   mem_l_d [FIFO_DEPTH];
   logic [IW-1:0]   mem_r_q [FIFO_DEPTH];
   logic [IW-1:0]   mem_r_d [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [IW-1:0]   out_l_q, out_l_d, out_r_q, out_r_d;
   logic            out_valid_q, out_valid_d;
   logic            overrun_q, overrun_d;
   logic            full_c, pop_c, push_c, drop_c;

   // Round half up, then narrow to IW bits (clamp or wrap).
   function automatic logic [IW-1:0] narrow(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] rnd;
      logic signed [RW-1:0] rs;
      rnd = p + RND_ADD;
      rs  = RW'(rnd >>> GAIN_SHIFT);
`ifdef AUDIO_DECIM_SAT_EN
      if (rs > SAT_MAX) begin
         narrow = IW'(SAT_MAX);
      end else if (rs < SAT_MIN) begin
         narrow = IW'(SAT_MIN);
      end else begin
         narrow = IW'(rs);
      end
`else
      narrow = IW'(rs);
`endif
   endfunction

   // Integrators chain within the cycle so the strobe sample reaches the last stage.
   always_comb begin
      int_l_d  = int_l_q;
      int_r_d  = int_r_q;
      phase_d  = phase_q;
      strobe_c = in_cen && (phase_q == PHW'(RATE - 1));
      if (in_cen) begin
         int_l_d[0] = int_l_q[0] + CW'(snd_l_in);
         int_r_d[0] = int_r_q[0] + CW'(snd_r_in);
         for (int k = 1; k < int'(STAGES); k++) begin
            int_l_d[k] = int_l_q[k] + int_l_d[k-1];
            int_r_d[k] = int_r_q[k] + int_r_d[k-1];
         end
         phase_d = strobe_c ? '0 : phase_q + PHW'(1);
      end
      prime_d = (strobe_c && (prime_q != PRW'(STAGES))) ? prime_q + PRW'(1) : prime_q;
   end

   // Comb chain at the decimated rate; results are only valid once every history holds a real strobe.
   always_comb begin
      hist_l_d   = hist_l_q;
      hist_r_d   = hist_r_q;
      comb_l_d   = comb_l_q;
      comb_r_d   = comb_r_q;
      cv_l       = int_l_d[STAGES-1];
      cv_r       = int_r_d[STAGES-1];
      comb_vld_d = strobe_c && (prime_q == PRW'(STAGES));
      if (strobe_c) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            hist_l_d[k] = cv_l;
            hist_r_d[k] = cv_r;
            cv_l        = cv_l - hist_l_q[k];
            cv_r        = cv_r - hist_r_q[k];
         end
         comb_l_d = cv_l;
         comb_r_d = cv_r;
      end
   end

   // Gain multiply, then round/narrow.
   always_comb begin
      prod_vld_d = comb_vld_q;
      prod_l_d   = prod_l_q;
      prod_r_d   = prod_r_q;
      if (comb_vld_q) begin
         prod_l_d = PW'($signed(comb_l_q)) * PW'(GAIN_S);
         prod_r_d = PW'($signed(comb_r_q)) * PW'(GAIN_S);
      end
      res_vld_d = prod_vld_q;
      res_l_d   = prod_vld_q ? narrow(prod_l_q) : res_l_q;
      res_r_d   = prod_vld_q ? narrow(prod_r_q) : res_r_q;
   end

   // FIFO: a push while full survives only if the head is popped in the same cycle.
   always_comb begin
      mem_l_d   = mem_l_q;
      mem_r_d   = mem_r_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      out_l_d   = out_l_q;
      out_r_d   = out_r_q;
      full_c    = (cnt_q == CNTW'(FIFO_DEPTH));
      pop_c     = out_valid_q && out_ready;
      push_c    = res_vld_q && (!full_c || pop_c);
      drop_c    = res_vld_q && full_c && !pop_c;
      overrun_d = overrun_q || drop_c;
      if (push_c) begin
         mem_l_d[wr_ptr_q] = res_l_q;
         mem_r_d[wr_ptr_q] = res_r_q;
         wr_ptr_d          = wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_c, pop_c})
         2'b10:   cnt_d = cnt_q + CNTW'(1);
         2'b01:   cnt_d = cnt_q - CNTW'(1);
         default: cnt_d = cnt_q;
      endcase
      out_valid_d = (cnt_d != '0);
      if (pop_c && (cnt_d != '0)) begin
         out_l_d = mem_l_d[rd_ptr_d];
         out_r_d = mem_r_d[rd_ptr_d];
      end else if (push_c && (cnt_q == '0)) begin
         out_l_d = res_l_q;
         out_r_d = res_r_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         int_l_q     <= '{default: '0};
         int_r_q     <= '{default: '0};
         hist_l_q    <= '{default: '0};
         hist_r_q    <= '{default: '0};
         phase_q     <= '0;
         prime_q     <= '0;
         comb_l_q    <= '0;
         comb_r_q    <= '0;
         comb_vld_q  <= 1'b0;
         prod_l_q    <= '0;
         prod_r_q    <= '0;
         prod_vld_q  <= 1'b0;
         res_l_q     <= '0;
         res_r_q     <= '0;
         res_vld_q   <= 1'b0;
         mem_l_q     <= '{default: '0};
         mem_r_q     <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         out_l_q     <= '0;
         out_r_q     <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         int_l_q     <= int_l_d;
         int_r_q     <= int_r_d;
         hist_l_q    <= hist_l_d;
         hist_r_q    <= hist_r_d;
         phase_q     <= phase_d;
         prime_q     <= prime_d;
         comb_l_q    <= comb_l_d;
         comb_r_q    <= comb_r_d;
         comb_vld_q  <= comb_vld_d;
         prod_l_q    <= prod_l_d;
         prod_r_q    <= prod_r_d;
         prod_vld_q  <= prod_vld_d;
         res_l_q     <= res_l_d;
         res_r_q     <= res_r_d;
         res_vld_q   <= res_vld_d;
         mem_l_q     <= mem_l_d;
         mem_r_q     <= mem_r_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         out_l_q     <= out_l_d;
         out_r_q     <= out_r_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_l     = out_l_q;
   assign out_r     = out_r_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: doc/audio_out_decimator.md
# audio_out_decimator

Stereo CIC decimator that runs at the opposite end of the audio path from the mclk-rate interpolation chain. It accepts the full-rate (53693136 Hz) left/right sample stream and reduces it by an integer factor to a DAC/serializer rate (47940 Hz by default). Output gain is normalised to unity, and samples are handed off through a small stereo FIFO with a valid/ready handshake. It sits between the resampler output and the audio serializer.

## Interface
- IW, 16: sample width, input and output, signed.
- RATE, 1120: integer decimation factor; 53693136/1120 = 47940 Hz.
- STAGES, 2: number of CIC integrator and comb stages; differential delay is 1.
- GAIN_MUL, 54783: unsigned normalisation multiplier, 17 bits.
- GAIN_SHIFT, 36: right shift applied after the multiply. GAIN_MUL/2^GAIN_SHIFT ≈ 1/RATE^STAGES.
- FIFO_DEPTH, 4: stereo-pair entries; must be a power of 2, ≥2.
- clk  in  1  system clock (mclk).
- reset_n  in  1  asynchronous, active-low reset.
- in_cen  in  1  input sample strobe; tie to 1 for mclk-rate input.
- snd_l_in  in  IW  signed left sample, sampled when in_cen=1.
- snd_r_in  in  IW  signed right sample, sampled when in_cen=1.
- out_l  out  IW  signed left sample at the FIFO head.
- out_r  out  IW  signed right sample at the FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head entry when out_valid=1 and out_ready=1.
- overrun  out  1  sticky flag; set when a result is dropped because the FIFO is full.

## Operation
- Internal width: CW = IW + STAGES·ceil(log2 RATE). Default CW = 38. All integrator and comb arithmetic is two's-complement modulo 2^CW; wrap is intentional.
- Integrators: on each in_cen, stage 1 += sign-extended input and stage k += stage k-1, per channel.
- Phase counter: 0..RATE-1, advances only on in_cen.
- Strobe: the in_cen cycle with counter == RATE-1. That cycle's sample is included in the integrators. The counter then wraps to 0.
- On strobe, the last integrator is latched into the comb chain: y_k = x_k − x_k(previous strobe), STAGES stages.
- Normalisation: p = comb_out · GAIN_MUL (signed × unsigned), then r = (p + 2^(GAIN_SHIFT−1)) >>> GAIN_SHIFT, i.e. round half up.
- Narrowing of r to IW bits: see Configuration.
- Priming: the first STAGES strobes after reset produce no FIFO write, because the comb history is not yet valid. Priming counter is 0..STAGES.
- FIFO write rules:
  - Each post-priming result pushes one {L,R} pair.
  - If the FIFO is full and no pop occurs in the same cycle, the pair is dropped and overrun is set.
  - Push and pop in the same cycle when full: the push is accepted and the count is unchanged.
- FIFO read: pop when out_valid & out_ready. out_l/out_r change only on a pop or on a write into an empty FIFO.
- FIFO state: wrapping read/write pointers plus an occupancy count, log2(FIFO_DEPTH)+1 bits.
- in_cen is ignored during the priming latency except for integration; priming never stalls the integrators.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): clears all integrators, comb histories, phase counter, priming counter, pipeline and FIFO pointers. Reset values: out_l=0, out_r=0, out_valid=0, overrun=0.
- Reset asserted mid-operation discards everything, including FIFO contents.
- Pipeline, with T = strobe cycle:
  - T+1: comb result registered.
  - T+2: product registered.
  - T+3: rounded/narrowed value written into the FIFO.
  - T+4: out_valid=1 (if the FIFO was previously empty) with out_l/out_r valid.
- Pop: out_valid and data update on the edge after the accepting cycle.
- Throughput: one pair per RATE in_cen pulses. The pipeline never stalls.
- Strobes are at least RATE cycles apart, so pipeline stages never collide.

## Configuration
- AUDIO_DECIM_SAT_EN defined: r is clamped to [−2^(IW−1), 2^(IW−1)−1] (−32768..32767 for IW=16).
- AUDIO_DECIM_SAT_EN undefined: r is truncated to its low IW bits (wrap). No comparator logic is built.

## Test plan
- DC +1000 on both channels, in_cen=1, out_ready=1 → first pair appears after the 3rd strobe (cycle 3·1120−1+4). All pairs then read exactly out_l=out_r=1000. Repeat with −1000 → exactly −1000.
- Left = +20000, right = −20000 → steady pairs (20000, −20000). Confirms no channel crosstalk.
- Square wave ±32767 with a 2-sample period plus a step to +32767, with AUDIO_DECIM_SAT_EN defined → no output exceeds 32767 or goes below −32768. Without the macro → bit-exact match to the modulo reference model.
- out_ready=0 for 6 post-priming strobes, DC 500 → FIFO holds 4 pairs, overrun=1 after the 5th result. Then out_ready=1 → exactly 4 pairs of 500 drain, out_valid=0, overrun stays 1.
- FIFO full and the consumer pops in the same cycle as a write → no drop, count stays 4, overrun stays 0.
- Assert reset_n=0 for 1 cycle mid-frame with the FIFO holding 2 pairs → out_valid=0 and overrun=0 immediately. Next output appears only after 3 new strobes.
